regbank_write_arbiter: RTL
==========================

Name: regbank_write_arbiter

Overview:
- Shares the register bank's single write port (WriteReg/WriteData/RegWrite) between two requesters:
  - A: ALU writeback.
  - B: memory-load writeback.
- Also sequences the bank's incr_pc input, which increments R7 (the PC).
- Sits directly in front of BancoRegistradores. All its outputs are registered and drive the bank ports of the same name.
- Provides round-robin fairness, a stall freeze, and a bounded queue of pending PC increments.

Parameters:
- PC_REG, 7: register index that holds the PC; a write to it overrides pending increments.
- PEND_W, 2: width of the pending-increment counter; saturates at 2^PEND_W-1 (3).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freeze: no grants, no incr_pc issue; pc_step still counted.
- a_valid  in  1  requester A holds a write.
- a_ready  out  1  A granted this cycle; combinational.
- a_reg  in  3  A destination register.
- a_data  in  16  A write data.
- b_valid  in  1  requester B holds a write.
- b_ready  out  1  B granted this cycle; combinational.
- b_reg  in  3  B destination register.
- b_data  in  16  B write data.
- pc_step  in  1  one-cycle request to add 1 to the PC.
- WriteReg  out  3  to bank.
- WriteData  out  16  to bank.
- RegWrite  out  1  to bank.
- incr_pc  out  1  to bank.
- pend_cnt  out  PEND_W  pending increments, for debug and verification.
- pc_ovf  out  1  sticky: a pc_step was lost to saturation.

Behaviour:
- Reset (synchronous, active-high):
  - RegWrite=0, incr_pc=0, WriteReg=0, WriteData=0, pend_cnt=0, pc_ovf=0.
  - last_grant=B, so A wins the first contended cycle.
  - Reset overrides stall and any in-flight handshake. A write accepted in the reset cycle is dropped; the requester must not rely on it.
- Grant (combinational, at most one per cycle):
  - No grant while stall=1 or reset=1.
  - Only A valid → grant A. Only B valid → grant B.
  - Both valid → grant the requester not in last_grant.
  - a_ready/b_ready equal the grant. A transfer occurs when valid&&ready at the edge. last_grant updates only on a transfer.
- Handshake: a requester holds valid, reg and data stable until ready. Ready never depends on a requester's own next-cycle state.
- Write latency:
  - Transfer at edge N → RegWrite=1, WriteReg and WriteData from the winner during cycle N+1.
  - The bank captures at edge N+2.
  - With no transfer at edge N, RegWrite=0 in cycle N+1. WriteReg and WriteData hold their previous values.
- Throughput: one write per cycle. Under continuous contention, grants strictly alternate.
- PC increment counter:
  - pend_next = pend_cnt + pc_step - issue, where issue = !stall && (pend_cnt + pc_step) > 0.
  - incr_pc is registered: it goes high in the cycle after an issue, with one increment per issue.
  - A pc_step with no stall and pend_cnt=0 yields incr_pc the next cycle (1-cycle latency).
  - Saturation: if pend_cnt=max, pc_step=1 and no issue, the count stays at max and pc_ovf sets. pc_ovf clears only on reset.
- PC override:
  - If the transfer at edge N targets PC_REG, pend_cnt clears to 0 and any pc_step in that cycle is discarded.
  - incr_pc in cycle N+1 is forced to 0, so RegWrite and incr_pc are never both high on R7.
  - The jump value wins; this matches the bank's write-over-increment priority.
- incr_pc may be high in the same cycle as RegWrite to R0–R6.
- stall=1: no transfers and no issues. RegWrite and incr_pc are 0 the next cycle. Pending increments accumulate.

Test Plan:
- Reset, idle → all outputs 0. Then a_valid with a_reg=3, a_data=0x1234 → a_ready=1 same cycle; next cycle RegWrite=1, WriteReg=3, WriteData=0x1234; following cycle RegWrite=0.
- a_valid and b_valid held for 6 cycles (A: R1/0x0001, B: R2/0x0002) → grant order A,B,A,B,A,B; RegWrite=1 for 6 consecutive cycles with alternating WriteReg 1,2.
- stall=1 for 4 cycles, pc_step pulsed in 4 of them → pend_cnt 1,2,3,3; pc_ovf=1. Release stall → incr_pc=1 for exactly 3 consecutive cycles; pend_cnt returns to 0.
- pend_cnt=2, then transfer of B with b_reg=7, b_data=0x0040 plus a simultaneous pc_step → next cycle RegWrite=1, WriteReg=7, incr_pc=0; pend_cnt=0; no later incr_pc.
- Transfer of A writing R5 in the same cycle as a pc_step with pend_cnt=0 → next cycle RegWrite=1 (R5) and incr_pc=1 together.
- reset asserted in the cycle after a transfer, with pend_cnt=3 and pc_ovf=1 → next cycle RegWrite=0, incr_pc=0, pend_cnt=0, pc_ovf=0; the first contended grant after reset goes to A.

Source files
------------

// File: rtl/regbank_write_arbiter.sv
// Shares the register bank write port between ALU (A) and load (B) writeback,
// and sequences PC increments with a saturating pending counter.
module regbank_write_arbiter #(
  parameter int unsigned PC_REG = 7,
  parameter int unsigned PEND_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_reg,
  input  logic [15:0]       a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [2:0]        b_reg,
  input  logic [15:0]       b_data,
  input  logic              pc_step,
  output logic [2:0]        WriteReg,
  output logic [15:0]       WriteData,
  output logic              RegWrite,
  output logic              incr_pc,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              pc_ovf
);

  localparam int unsigned SUM_W    = PEND_W + 1;
  localparam int unsigned PEND_MAX = (2 ** PEND_W) - 1;

  typedef enum logic {LG_A, LG_B} grant_t;

  grant_t             last_grant, last_grant_nxt;
  logic               xfer;
  logic [2:0]         xfer_reg;
  logic [15:0]        xfer_data;
  logic               pc_hit;
  logic               issue;
  logic               sat;
  logic [SUM_W-1:0]   pend_sum;
  logic [SUM_W-1:0]   pend_dec;
  logic [2:0]         write_reg_nxt;
  logic [15:0]        write_data_nxt;
  logic               reg_write_nxt;
  logic               incr_pc_nxt;
  logic [PEND_W-1:0]  pend_cnt_nxt;
  logic               pc_ovf_nxt;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= LG_B;
      RegWrite   <= 1'b0;
      incr_pc    <= 1'b0;
      WriteReg   <= '0;
      WriteData  <= '0;
      pend_cnt   <= '0;
      pc_ovf     <= 1'b0;
    end else begin
      last_grant <= last_grant_nxt;
      RegWrite   <= reg_write_nxt;
      incr_pc    <= incr_pc_nxt;
      WriteReg   <= write_reg_nxt;
      WriteData  <= write_data_nxt;
      pend_cnt   <= pend_cnt_nxt;
      pc_ovf     <= pc_ovf_nxt;
    end
  end

  // Round-robin grant, write staging and PC increment bookkeeping
  always_comb begin
    a_ready        = 1'b0;
    b_ready        = 1'b0;
    last_grant_nxt = last_grant;
    write_reg_nxt  = WriteReg;
    write_data_nxt = WriteData;
    pc_ovf_nxt     = pc_ovf;
    sat            = 1'b0;

    if (!reset && !stall) begin
      if (a_valid && (!b_valid || last_grant == LG_B)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end

    xfer      = a_ready || b_ready;
    xfer_reg  = a_ready ? a_reg  : b_reg;
    xfer_data = a_ready ? a_data : b_data;
    pc_hit    = xfer && (xfer_reg == 3'(PC_REG));

    if (a_ready) begin
      last_grant_nxt = LG_A;
    end else if (b_ready) begin
      last_grant_nxt = LG_B;
    end

    reg_write_nxt = xfer;
    if (xfer) begin
      write_reg_nxt  = xfer_reg;
      write_data_nxt = xfer_data;
    end

    pend_sum = {1'b0, pend_cnt} + SUM_W'(pc_step);
    issue    = !stall && (pend_sum != '0);
    pend_dec = pend_sum - SUM_W'(issue);

    // A jump to the PC discards pending and same-cycle increments
    if (pc_hit) begin
      pend_cnt_nxt = '0;
      incr_pc_nxt  = 1'b0;
    end else begin
      incr_pc_nxt = issue;
      if (pend_dec > SUM_W'(PEND_MAX)) begin
        sat          = 1'b1;
        pend_cnt_nxt = PEND_W'(PEND_MAX);
      end else begin
        pend_cnt_nxt = pend_dec[PEND_W-1:0];
      end
    end

    if (sat) begin
      pc_ovf_nxt = 1'b1;
    end
  end

endmodule
